// File: rtl/demux_loader_if.sv
// Handshake and slot bus for demux_loader.
// The master drives the word stream; the slave exposes the loaded slots.
interface demux_loader_if #(
    parameter int WIDTH      = 32,
    parameter int OUTPUT_NUM = 5
);
    localparam int SEL_WIDTH = $clog2(OUTPUT_NUM);

    logic                        start;
    logic [SEL_WIDTH-1:0]        start_sel;
    logic                        in_valid;
    logic [WIDTH-1:0]            in_data;
    logic                        in_ready;
    logic [OUTPUT_NUM*WIDTH-1:0] out_put;
    logic [OUTPUT_NUM-1:0]       slot_valid;
    logic                        busy;
    logic                        frame_done;

    modport master (
        output start, start_sel, in_valid, in_data,
        input  in_ready, out_put, slot_valid, busy, frame_done
    );

    modport slave (
        input  start, start_sel, in_valid, in_data,
        output in_ready, out_put, slot_valid, busy, frame_done
    );
endinterface

// File: rtl/demux_loader.sv
// Sequential 1-to-N demux loading OUTPUT_NUM registered slots per frame.
// Define DEMUX_LOADER_CLEAR_ON_START_EN to zero all slots when a frame starts.
module demux_loader #(
    parameter int WIDTH      = 32,
    parameter int OUTPUT_NUM = 5
) (
    input  logic           clk,
    input  logic           rst,
    demux_loader_if.slave  bus
);
    localparam int SEL_WIDTH = $clog2(OUTPUT_NUM);
    localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(OUTPUT_NUM - 1);
    localparam logic [SEL_WIDTH:0]   NUM  = (SEL_WIDTH + 1)'(OUTPUT_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [SEL_WIDTH-1:0]        ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0]        cnt_q, cnt_d;
    logic [OUTPUT_NUM*WIDTH-1:0] data_q, data_d;
    logic [OUTPUT_NUM-1:0]       valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Out-of-range start slots fall back to slot 0
                    ptr_d   = ({1'b0, bus.start_sel} >= NUM) ? '0 : bus.start_sel;
                    cnt_d   = '0;
                    valid_d = '0;
`ifdef DEMUX_LOADER_CLEAR_ON_START_EN
                    data_d  = '0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    data_d[ptr_q*WIDTH +: WIDTH] = bus.in_data;
                    valid_d[ptr_q]               = 1'b1;
                    ptr_d = (ptr_q == LAST) ? '0 : ptr_q + SEL_WIDTH'(1);
                    cnt_d = cnt_q + SEL_WIDTH'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready   = (state_q == LOAD);
    assign bus.out_put    = data_q;
    assign bus.slot_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
endmodule
